// File: rtl/alu_ops_pkg.sv
// Shared ALU long-op codes, multiply/divide FSM states and latched request flags.
package alu_ops_pkg;

   localparam logic [3:0] ALU_MULTU = 4'b1100;
   localparam logic [3:0] ALU_DIVU  = 4'b1101;
   localparam logic [3:0] ALU_MULT  = 4'b1110;
   localparam logic [3:0] ALU_DIV   = 4'b1111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } md_state_e;

   // Per-request flags captured on the start edge.
   typedef struct packed {
      logic is_div;   // divide (else multiply)
      logic sign_q;   // product / quotient must be negated
      logic sign_r;   // remainder must be negated (dividend sign)
      logic dz;       // divide by zero
      logic ovf;      // signed most-negative / -1
   } md_op_t;

endpackage

// File: rtl/md_cond_neg.sv
// Conditional two's-complement negate: y_c = neg ? -a : a.
module md_cond_neg #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic             neg,
   output logic [WIDTH-1:0] y_c
);

   // Invert-and-increment when negation is requested.
   always_comb begin
      y_c = a;
      if (neg) y_c = ~a + WIDTH'(1);
   end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide engine: one bit per clock, HI/LO result with done strobe.
module mul_div_unit
   import alu_ops_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       control,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] out1,
   output logic [WIDTH-1:0] out2,
   output logic             o,
   output logic             z
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   md_state_e          state, state_nxt;
   logic [CNT_W-1:0]   cnt;
   md_op_t             op;
   logic [WIDTH:0]     rem;    // MUL: high accumulator; DIV: partial remainder (with borrow bit)
   logic [WIDTH-1:0]   mq;     // MUL: multiplier -> product low; DIV: dividend -> quotient
   logic [WIDTH-1:0]   dsr;    // multiplicand / divisor magnitude

   logic               is_div_c, is_sgn_c, s1_c, s2_c, accept_c, last_c;
   logic [WIDTH-1:0]   abs1_c, abs2_c;
   logic [WIDTH:0]     mul_sum_c, div_shift_c, div_diff_c;
   logic               div_ok_c;
   logic [2*WIDTH-1:0] prod_fix_c;
   logic [WIDTH-1:0]   quot_fix_c, rem_fix_c, fix_hi_c, fix_lo_c;

   assign is_div_c = control inside {ALU_DIVU, ALU_DIV};
   assign is_sgn_c = control inside {ALU_MULT, ALU_DIV};
   assign s1_c     = is_sgn_c & in1[WIDTH-1];
   assign s2_c     = is_sgn_c & in2[WIDTH-1];
   assign accept_c = (state == IDLE) && start && (control[3:2] == 2'b11);
   assign last_c   = (cnt == CNT_W'(WIDTH-1));

   md_cond_neg #(.WIDTH(WIDTH)) u_abs1 (.a(in1), .neg(s1_c), .y_c(abs1_c));
   md_cond_neg #(.WIDTH(WIDTH)) u_abs2 (.a(in2), .neg(s2_c), .y_c(abs2_c));

   md_cond_neg #(.WIDTH(2*WIDTH)) u_fix_prod (
      .a({rem[WIDTH-1:0], mq}), .neg(op.sign_q), .y_c(prod_fix_c));
   md_cond_neg #(.WIDTH(WIDTH)) u_fix_quot (.a(mq), .neg(op.sign_q), .y_c(quot_fix_c));
   md_cond_neg #(.WIDTH(WIDTH)) u_fix_rem  (.a(rem[WIDTH-1:0]), .neg(op.sign_r), .y_c(rem_fix_c));

   // One iteration step: shift-add for MUL, restoring shift-subtract for DIV.
   always_comb begin
      mul_sum_c   = rem + (mq[0] ? {1'b0, dsr} : (WIDTH+1)'(0));
      div_shift_c = {rem[WIDTH-1:0], mq[WIDTH-1]};
      div_diff_c  = div_shift_c - {1'b0, dsr};
      div_ok_c    = ~div_diff_c[WIDTH];
   end

   // Sign fix-up and divide-by-zero override of the final result.
   always_comb begin
      fix_hi_c = prod_fix_c[2*WIDTH-1:WIDTH];
      fix_lo_c = prod_fix_c[WIDTH-1:0];
      if (op.is_div) begin
         fix_hi_c = rem_fix_c;
         fix_lo_c = op.dz ? '1 : quot_fix_c;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept_c) state_nxt = CALC;
         CALC:    if (last_c)   state_nxt = FIX;
         FIX:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Operand latch, iteration datapath and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         op   <= '0;
         rem  <= '0;
         mq   <= '0;
         dsr  <= '0;
         busy <= 1'b0;
         done <= 1'b0;
         out1 <= '0;
         out2 <= '0;
         o    <= 1'b0;
         z    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept_c) begin
                  busy      <= 1'b1;
                  cnt       <= '0;
                  op.is_div <= is_div_c;
                  op.sign_q <= s1_c ^ s2_c;
                  op.sign_r <= s1_c;
                  op.dz     <= is_div_c && (in2 == '0);
                  op.ovf    <= is_div_c && is_sgn_c && (in2 == '1) &&
                               (in1 == {1'b1, (WIDTH-1)'(0)});
                  rem       <= '0;
                  mq        <= abs1_c;
                  dsr       <= abs2_c;
               end
            end
            CALC: begin
               cnt <= cnt + CNT_W'(1);
               if (op.is_div) begin
                  rem <= div_ok_c ? div_diff_c : div_shift_c;
                  mq  <= {mq[WIDTH-2:0], div_ok_c};
               end else begin
                  rem <= {1'b0, mul_sum_c[WIDTH:1]};
                  mq  <= {mul_sum_c[0], mq[WIDTH-1:1]};
               end
            end
            FIX: begin
               out1 <= fix_hi_c;
               out2 <= fix_lo_c;
               o    <= op.dz | op.ovf;
               z    <= (fix_hi_c == '0) && (fix_lo_c == '0);
               done <= 1'b1;
               busy <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed requests push expectations, monitor checks on done.
module tb_mul_div_unit;
   import alu_ops_pkg::*;

   localparam int unsigned W = 32;
   localparam int LAT = 34;  // drive negedge -> negedge on which done is visible

   logic          clk, rst_n, start;
   logic [3:0]    control;
   logic [W-1:0]  in1, in2;
   logic          busy, done, o, z;
   logic [W-1:0]  out1, out2;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         ov;
      logic         zr;
      int           due;
      string        name;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   cyc = 0;
   int   ndone = 0;
   int   total = 0;
   int   passed = 0;
   logic prev_done = 1'b0;

   mul_div_unit #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .control(control),
      .in1(in1), .in2(in2), .busy(busy), .done(done),
      .out1(out1), .out2(out2), .o(o), .z(z)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n && done) begin
         ndone++;
         chk("done_expected", 64'(sb.size() != 0), 64'(1));
         chk("done_one_cycle", 64'(prev_done), 64'(0));
         chk("busy_low_on_done", 64'(busy), 64'(0));
         if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            chk({mon_e.name, "_latency"}, 64'(cyc), 64'(mon_e.due));
            chk({mon_e.name, "_out1"}, 64'(out1), 64'(mon_e.hi));
            chk({mon_e.name, "_out2"}, 64'(out2), 64'(mon_e.lo));
            chk({mon_e.name, "_o"}, 64'(o), 64'(mon_e.ov));
            chk({mon_e.name, "_z"}, 64'(z), 64'(mon_e.zr));
         end
      end
      prev_done = done;
   end

   task automatic push(input logic [W-1:0] eh, input logic [W-1:0] el,
                       input logic eo, input logic ez, input int due, input string nm);
      exp_t e;
      e.hi = eh; e.lo = el; e.ov = eo; e.zr = ez; e.due = due; e.name = nm;
      sb.push_back(e);
   endtask

   // Issue one request; operands are scrambled right after the start edge.
   task automatic issue(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eh, input logic [W-1:0] el,
                        input logic eo, input logic ez, input string nm);
      @(negedge clk);
      control = c; in1 = a; in2 = b; start = 1'b1;
      push(eh, el, eo, ez, cyc + LAT, nm);
      @(posedge clk);
      #1 start = 1'b0; in1 = ~a; in2 = ~b; control = ~c;
      @(negedge clk);
      chk({nm, "_busy"}, 64'(busy), 64'(1));
   endtask

   task automatic drain(input string nm);
      for (int i = 0; i < 200; i++) begin
         if (sb.size() == 0) break;
         @(negedge clk);
      end
      chk({nm, "_drained"}, 64'(sb.size()), 64'(0));
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0, nd0;
      rst_n = 1'b0; start = 1'b0; control = 4'b0000; in1 = '0; in2 = '0;
      repeat (2) @(negedge clk);
      chk("reset_state", {58'd0, busy, done, o, z, |out1, |out2}, 64'd0);
      rst_n = 1'b1;

      // Non-long control is ignored.
      @(negedge clk);
      control = 4'b0101; in1 = 32'd9; in2 = 32'd3; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      chk("ignore_bad_ctrl_busy", 64'(busy), 64'(0));

      issue(ALU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0, 0, "multu_max");
      drain("multu_max");
      issue(ALU_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 0, 0, "mult_neg3x5");
      drain("mult_neg3x5");
      issue(ALU_MULT, 32'd0, 32'h1234, 32'd0, 32'd0, 0, 1, "mult_zero");
      drain("mult_zero");
      issue(ALU_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0, 0, 0, "mult_min_sq");
      drain("mult_min_sq");
      issue(ALU_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 0, 0, "divu_100_7");
      drain("divu_100_7");
      issue(ALU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 0, "div_neg7_2");
      drain("div_neg7_2");
      issue(ALU_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 0, 0, "div_7_neg2");
      drain("div_7_neg2");
      issue(ALU_DIVU, 32'h55, 32'd0, 32'h55, 32'hFFFF_FFFF, 1, 0, "divu_by0");
      drain("divu_by0");
      issue(ALU_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1, 0, "div_by0");
      drain("div_by0");
      issue(ALU_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 0, 0, "o_clears");
      drain("o_clears");

      // Start while busy is dropped.
      nd0 = ndone;
      issue(ALU_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 0, 0, "busy_start");
      repeat (3) @(negedge clk);
      control = ALU_MULTU; in1 = 32'd3; in2 = 32'd3; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      drain("busy_start");
      repeat (40) @(negedge clk);
      chk("busy_start_one_done", 64'(ndone - nd0), 64'(1));

      // Start held high across done: second request accepted on the done cycle.
      @(negedge clk);
      control = ALU_DIVU; in1 = 32'd100; in2 = 32'd7; start = 1'b1;
      c0 = cyc;
      push(32'd2, 32'd14, 0, 0, c0 + LAT, "held_first");
      repeat (LAT) @(negedge clk);
      chk("held_done_seen", 64'(done), 64'(1));
      control = ALU_MULTU; in1 = 32'd3; in2 = 32'd3;
      push(32'd0, 32'd9, 0, 0, cyc + LAT, "held_second");
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      chk("held_second_busy", 64'(busy), 64'(1));
      drain("held");

      // Leave non-zero outputs and o=1, then abort a MULT with reset.
      issue(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1, 0, "div_ovf");
      drain("div_ovf");
      nd0 = ndone;
      issue(ALU_MULT, 32'd1234, 32'd5678, 32'd0, 32'd7006652, 0, 0, "mult_abort");
      repeat (8) @(negedge clk);
      #2 rst_n = 1'b0;
      sb.delete();
      #1 chk("async_reset_outputs", {58'd0, busy, done, o, z, |out1, |out2}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("abort_no_done", 64'(ndone - nd0), 64'(0));
      issue(ALU_MULT, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd0, 32'd6, 0, 0, "after_reset");
      drain("after_reset");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
